// File: rtl/mul_dot_acc.sv
// Dot-product accumulator behind the 8-bit multiplier: sums DOT_LEN valid products per result and queues results in a FIFO.
// Latency: a result is visible (out_valid=1) on the cycle after the edge that samples its last product.
// Backpressure: the input never stalls; a result completing into a full FIFO (with no same-cycle pop) is dropped and flagged.
//
// Optional feature: define MUL_DOT_ACC_SATURATE_EN to make the accumulator saturate at 2^ACC_W-1 (flagged on sat_err);
// without it sums wrap modulo 2^ACC_W and sat_err is tied low.

// Result FIFO: circular buffer with registered storage, head muxed by the read pointer.
// Latency: one cycle from push to pop_vld; no bypass from push to pop.
// Backpressure: push_rdy is low when full unless a pop happens in the same cycle.
module mul_dot_acc_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    output logic                       push_rdy,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          pop;
    logic          push;

    assign full     = (count == CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop      = pop_vld & pop_rdy;
    // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
    assign push_rdy = ~full | pop;
    assign push     = push_vld & push_rdy;
    // Output reads as zero when empty so stale storage never leaks out.
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because the head is gated by pop_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// Dot-product accumulator top.
// Latency: one cycle from the last product's sampling edge to out_valid.
// Backpressure: out_ready only throttles the FIFO; the product input is never stalled.
module mul_dot_acc #(
    parameter int size       = 8,
    parameter int DOT_LEN    = 4,
    parameter int ACC_W      = 2*size + 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mul_en_out,
    input  logic [2*size-1:0]             mul_out,
    input  logic                          acc_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          drop_err,
    output logic                          sat_err
);

    // A counter width of at least one bit keeps DOT_LEN=1 legal.
    localparam int CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DOT_LEN - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W-1:0] sum;
    logic             last;
    logic             push;
    logic             push_rdy;
    logic             push_drop;

    // acc_clr restarts the sum this cycle, so a same-cycle product becomes the first term.
    assign acc_base = acc_clr ? '0 : acc;
    assign cnt_base = acc_clr ? '0 : cnt;
    assign last     = (cnt_base == LAST);
    assign push     = mul_en_out & last;
    assign push_drop = push & ~push_rdy;

`ifdef MUL_DOT_ACC_SATURATE_EN
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W:0] sum_wide;
    logic           carry;

    // One extra bit catches overflow; the sum then clamps to all ones.
    assign sum_wide = {1'b0, acc_base} + SUM_W'(mul_out);
    assign carry    = sum_wide[ACC_W];
    assign sum      = carry ? '1 : sum_wide[ACC_W-1:0];

    // Sticky saturation flag; acc_clr clears it, but a cleared sum cannot itself carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_err <= 1'b0;
        end else begin
            sat_err <= (sat_err & ~acc_clr) | (mul_en_out & carry);
        end
    end
`else
    // Plain modular addition; the product is zero-extended into the accumulator width.
    assign sum     = acc_base + ACC_W'(mul_out);
    assign sat_err = 1'b0;
`endif

    // Partial-sum register and product counter; a completed sum leaves through the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (mul_en_out) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt_base + CNT_W'(1);
            end
        end else if (acc_clr) begin
            acc <= '0;
            cnt <= '0;
        end
    end

    // Sticky drop flag; a drop in the same cycle as acc_clr still sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else begin
            drop_err <= (drop_err & ~acc_clr) | push_drop;
        end
    end

    mul_dot_acc_fifo #(
        .W     (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (sum),
        .push_rdy (push_rdy),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (out_data),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_mul_dot_acc.sv
// Testbench for mul_dot_acc with ACC_W=17 so saturation/wrap is reachable with 16-bit products.
// Directed steps plus randomized traffic, compared every cycle against a queue-based reference model.
// Expected saturation results depend on MUL_DOT_ACC_SATURATE_EN exactly as the design does.
module tb_mul_dot_acc;

    localparam int SIZE    = 8;
    localparam int DOT_LEN = 4;
    localparam int ACC_W   = 17;
    localparam int DEPTH   = 4;
    localparam longint MOD = 64'd1 << ACC_W;

    logic                 clk;
    logic                 rst_n;
    logic                 mul_en_out;
    logic [2*SIZE-1:0]    mul_out;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic [2:0]           fifo_cnt;
    logic                 drop_err;
    logic                 sat_err;

    int nvec = 0;
    int nerr = 0;

    // Reference model state.
    longint m_acc;
    int     m_cnt;
    longint q[$];
    bit     m_drop;
    bit     m_sat;

    mul_dot_acc #(
        .size       (SIZE),
        .DOT_LEN    (DOT_LEN),
        .ACC_W      (ACC_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_en_out (mul_en_out),
        .mul_out    (mul_out),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_cnt   (fifo_cnt),
        .drop_err   (drop_err),
        .sat_err    (sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_cnt  = 0;
        m_drop = 0;
        m_sat  = 0;
        q.delete();
    endtask

    // Advance the model by one clock edge using the inputs held during that cycle.
    task automatic model_edge();
        bit     pop;
        bit     push;
        longint s;
        pop  = (q.size() != 0) && out_ready;
        push = 0;
        s    = 0;
        if (acc_clr) begin
            m_acc  = 0;
            m_cnt  = 0;
            m_drop = 0;
            m_sat  = 0;
        end
        if (mul_en_out) begin
            s = m_acc + longint'(mul_out);
            if (s >= MOD) begin
`ifdef MUL_DOT_ACC_SATURATE_EN
                s     = MOD - 1;
                m_sat = 1;
`else
                s = s - MOD;
`endif
            end
            m_cnt++;
            if (m_cnt == DOT_LEN) begin
                push  = 1;
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_acc = s;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(s);
            else m_drop = 1;
        end
    endtask

    task automatic check_all();
        longint head;
        head = (q.size() != 0) ? q[0] : 0;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data",  32'(out_data),  32'(head));
        chk("fifo_cnt",  32'(fifo_cnt),  32'(q.size()));
        chk("drop_err",  32'(drop_err),  32'(m_drop));
        chk("sat_err",   32'(sat_err),   32'(m_sat));
    endtask

    // Apply one cycle of inputs, clock it, then compare a little after the edge.
    task automatic step(input logic en, input logic [15:0] p, input logic clr, input logic rdy);
        mul_en_out = en;
        mul_out    = p;
        acc_clr    = clr;
        out_ready  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst_n      = 1'b0;
        mul_en_out = 1'b0;
        mul_out    = '0;
        acc_clr    = 1'b0;
        out_ready  = 1'b0;
        model_reset();

        // Reset state.
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_cnt",   32'(fifo_cnt),  0);
        chk("rst_drop",  32'(drop_err),  0);
        chk("rst_sat",   32'(sat_err),   0);
        #9;
        rst_n = 1'b1;

        // Reset mid-operation: two queued results and a partial sum of two products.
        for (int i = 0; i < 10; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(fifo_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data",  32'(out_data),  0);
        chk("async_rst_cnt",   32'(fifo_cnt),  0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
        chk("post_rst_sum", 32'(out_data), 4);
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Basic sum on consecutive cycles.
        step(1'b1, 16'd15,  1'b0, 1'b1);
        step(1'b1, 16'd100, 1'b0, 1'b1);
        step(1'b1, 16'd255, 1'b0, 1'b1);
        step(1'b1, 16'd1,   1'b0, 1'b1);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_sum",   32'(out_data),  371);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("basic_one_cycle", 32'(out_valid), 0);

        // Same sum with three idle cycles (garbage on mul_out) between products.
        step(1'b1, 16'd15, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 1'b0, 1'b1);
        step(1'b1, 16'd100, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 1'b0, 1'b1);
        step(1'b1, 16'd255, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom), 1'b0, 1'b1);
        step(1'b1, 16'd1, 1'b0, 1'b1);
        chk("gap_sum", 32'(out_data), 371);
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Fill the FIFO, drop a fifth result, drain in order.
        for (int r = 1; r <= 4; r++)
            for (int i = 0; i < 4; i++) step(1'b1, 16'(r), 1'b0, 1'b0);
        chk("full_cnt",  32'(fifo_cnt), 4);
        chk("full_drop", 32'(drop_err), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd5, 1'b0, 1'b0);
        chk("drop_flag", 32'(drop_err), 1);
        chk("drop_cnt",  32'(fifo_cnt), 4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", 32'(out_data), 32'(4 * k));
            step(1'b0, 16'd0, 1'b0, 1'b1);
        end
        chk("drained", 32'(out_valid), 0);

        // acc_clr discards the partial sum and clears the sticky drop flag.
        step(1'b1, 16'd10, 1'b0, 1'b1);
        step(1'b1, 16'd20, 1'b0, 1'b1);
        chk("clr_pre_drop", 32'(drop_err), 1);
        step(1'b1, 16'd7, 1'b1, 1'b1);
        chk("clr_drop", 32'(drop_err), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'd1, 1'b0, 1'b1);
        chk("clr_sum", 32'(out_data), 10);
        step(1'b0, 16'd0, 1'b0, 1'b1);

        // Push into a full FIFO with a same-cycle pop.
        for (int r = 1; r <= 4; r++)
            for (int i = 0; i < 4; i++) step(1'b1, 16'(r), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'd5, 1'b0, 1'b0);
        step(1'b1, 16'd5, 1'b0, 1'b1);
        chk("pushpop_cnt",  32'(fifo_cnt), 4);
        chk("pushpop_drop", 32'(drop_err), 0);
        chk("pushpop_head", 32'(out_data), 8);
        for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 1'b0, 1'b1);

        // Saturation or wrap with ACC_W=17.
        for (int i = 0; i < 4; i++) step(1'b1, 16'd65025, 1'b0, 1'b1);
`ifdef MUL_DOT_ACC_SATURATE_EN
        chk("sat_sum",  32'(out_data), 131071);
        chk("sat_flag", 32'(sat_err),  1);
`else
        chk("wrap_sum",  32'(out_data), 129028);
        chk("wrap_flag", 32'(sat_err),  0);
`endif
        step(1'b0, 16'd0, 1'b1, 1'b1);
        chk("sat_clr", 32'(sat_err), 0);

        // Ten results with out_ready toggling every cycle, across pointer wrap.
        for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b0, 1'(i % 2 == 0));
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 1'b0, 1'b1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
        chk("final_empty", 32'(fifo_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
